// File: rtl/lbp_stream_engine_if.sv
// Bundles the gray-memory read port and the LBP-memory write port of the engine.
// master: engine side (issues reads and writes); slave: memory / environment side.
// Widths follow the image geometry: address = log2(W)+log2(H) bits, data = PIX_W bits.
interface lbp_stream_engine_if #(
  parameter int IMG_W_LOG2 = 7,
  parameter int IMG_H_LOG2 = 7,
  parameter int PIX_W      = 8
);
  localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;

  logic             gray_ready;
  logic             gray_req;
  logic [AW-1:0]    gray_addr;
  logic [PIX_W-1:0] gray_data;
  logic             lbp_valid;
  logic [AW-1:0]    lbp_addr;
  logic [7:0]       lbp_data;
  logic             finish;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 local-binary-pattern engine over a 2^IMG_W_LOG2 x 2^IMG_H_LOG2 raster image.
// Latency: one LBP write per captured pixel, issued the cycle after capture; finish <= W*H+W+2 cycles after start.
// Backpressure: gray_ready low stalls the scan (gray_req low, gray_addr held); results already computed still issue.
// Ports: clk, reset (sync, active-high); bus.gray_ready/gray_req/gray_addr/gray_data read each pixel once,
//        bus.lbp_valid/lbp_addr/lbp_data write codes in increasing address order, bus.finish sticky until reset.
module lbp_stream_engine #(
  parameter int IMG_W_LOG2   = 7,
  parameter int IMG_H_LOG2   = 7,
  parameter int PIX_W        = 8,
  parameter bit BORDER_WRITE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  lbp_stream_engine_if.master  bus
);
  localparam int W  = 1 << IMG_W_LOG2;
  localparam int H  = 1 << IMG_H_LOG2;
  localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(W * H - 1);
  // Output address trails the capture address by one row plus one pixel: capturing (x,y)
  // completes the window centred on (x-1,y-1).
  localparam logic [AW-1:0] LAG         = AW'(W + 1);
  // Addresses never reached by the trailing pointer: right edge of row H-2 and all of row H-1.
  localparam logic [AW-1:0] DRAIN_FIRST = AW'(W * H - W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                 state;
  logic [AW-1:0]          rd_addr;
  logic [AW-1:0]          dr_addr;
  logic                   drain_end;

  // Line buffers: lb0 holds row y-2, lb1 holds row y-1, indexed by column.
  // They carry no valid bits: every row is refilled before any window reads it.
  logic [PIX_W-1:0]       lb0 [W];
  logic [PIX_W-1:0]       lb1 [W];
  // Window columns x-2 (col_a) and x-1 (col_b); index 0 = top row, 1 = middle, 2 = bottom.
  // Column x comes straight from the line buffers and the incoming pixel.
  logic [PIX_W-1:0]       col_a [3];
  logic [PIX_W-1:0]       col_b [3];

  logic                   capture;
  logic [IMG_W_LOG2-1:0]  cur_x;
  logic [IMG_H_LOG2-1:0]  cur_y;
  logic [PIX_W-1:0]       new_top;
  logic [PIX_W-1:0]       new_mid;
  logic [PIX_W-1:0]       center;
  logic [7:0]             code;
  logic                   interior;

  assign capture       = (state == FETCH) && bus.gray_ready;
  assign cur_x         = rd_addr[IMG_W_LOG2-1:0];
  assign cur_y         = rd_addr[AW-1:IMG_W_LOG2];
  assign bus.gray_req  = capture;
  assign bus.gray_addr = rd_addr;

  always_comb begin
    new_top  = lb0[cur_x];
    new_mid  = lb1[cur_x];
    center   = col_b[1];
    // Neighbour k order: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1).
    code[0]  = (col_a[0]      >= center);
    code[1]  = (col_b[0]      >= center);
    code[2]  = (new_top       >= center);
    code[3]  = (col_a[1]      >= center);
    code[4]  = (new_mid       >= center);
    code[5]  = (col_a[2]      >= center);
    code[6]  = (col_b[2]      >= center);
    code[7]  = (bus.gray_data >= center);
    interior = (cur_x >= IMG_W_LOG2'(2)) && (cur_y >= IMG_H_LOG2'(2));
  end

  // Pixel storage; no reset needed since contents are rewritten before use.
  always_ff @(posedge clk) begin
    if (capture) begin
      lb0[cur_x] <= new_mid;
      lb1[cur_x] <= bus.gray_data;
      col_a      <= col_b;
      col_b[0]   <= new_top;
      col_b[1]   <= new_mid;
      col_b[2]   <= bus.gray_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rd_addr       <= '0;
      dr_addr       <= '0;
      drain_end     <= 1'b0;
      bus.lbp_valid <= 1'b0;
      bus.lbp_addr  <= '0;
      bus.lbp_data  <= 8'h00;
      bus.finish    <= 1'b0;
    end else begin
      bus.lbp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.gray_ready) state <= FETCH;
        end
        FETCH: begin
          if (bus.gray_ready) begin
            // Each capture releases exactly one trailing address, so writes never collide.
            if ((rd_addr >= LAG) && (interior || BORDER_WRITE)) begin
              bus.lbp_valid <= 1'b1;
              bus.lbp_addr  <= rd_addr - LAG;
              bus.lbp_data  <= interior ? code : 8'h00;
            end
            if (rd_addr == LAST_ADDR) begin
              state     <= DRAIN;
              dr_addr   <= DRAIN_FIRST;
              drain_end <= !BORDER_WRITE;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state      <= DONE;
            bus.finish <= 1'b1;
          end else begin
            bus.lbp_valid <= 1'b1;
            bus.lbp_addr  <= dr_addr;
            bus.lbp_data  <= 8'h00;
            dr_addr       <= dr_addr + AW'(1);
            drain_end     <= (dr_addr == LAST_ADDR);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbp_stream_engine.sv
module tb_lbp_stream_engine;
  localparam int NA = 16384;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_stream_engine_if #(.IMG_W_LOG2(7), .IMG_H_LOG2(7), .PIX_W(8))  ia ();
  lbp_stream_engine_if #(.IMG_W_LOG2(7), .IMG_H_LOG2(7), .PIX_W(8))  ib ();
  lbp_stream_engine_if #(.IMG_W_LOG2(3), .IMG_H_LOG2(3), .PIX_W(10)) ic ();

  lbp_stream_engine #(.IMG_W_LOG2(7), .IMG_H_LOG2(7), .PIX_W(8), .BORDER_WRITE(1'b0))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  lbp_stream_engine #(.IMG_W_LOG2(7), .IMG_H_LOG2(7), .PIX_W(8), .BORDER_WRITE(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(ib));
  lbp_stream_engine #(.IMG_W_LOG2(3), .IMG_H_LOG2(3), .PIX_W(10), .BORDER_WRITE(1'b0))
    dut_c (.clk(clk), .reset(reset), .bus(ic));

  logic [9:0] gm [3][NA];
  logic [7:0] lm [3][NA];
  int         wn [3][NA];
  int req_cnt [3];
  int req_err [3];
  int req_next[3];
  int wr_cnt  [3];
  int wr_err  [3];
  int wr_last [3];
  int n_assert = 0;
  int n_fail   = 0;

  assign ia.gray_data = gm[0][ia.gray_addr][7:0];
  assign ib.gray_data = gm[1][ib.gray_addr][7:0];
  assign ic.gray_data = gm[2][{8'd0, ic.gray_addr}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Records requests and writes; sequence and ordering faults are tallied for later checks.
  task automatic mon(input logic [1:0] d, input logic req, input logic [13:0] ra,
                     input logic vld, input logic [13:0] wa, input logic [7:0] wd);
    if (req === 1'b1) begin
      if (int'(ra) != req_next[d]) req_err[d]++;
      req_next[d] = int'(ra) + 1;
      req_cnt[d]++;
    end
    if (vld === 1'b1) begin
      if (int'(wa) <= wr_last[d]) wr_err[d]++;
      wr_last[d] = int'(wa);
      wr_cnt[d]++;
      lm[d][wa] = wd;
      wn[d][wa]++;
    end
  endtask

  always @(posedge clk) mon(2'd0, ia.gray_req, ia.gray_addr, ia.lbp_valid, ia.lbp_addr, ia.lbp_data);
  always @(posedge clk) mon(2'd1, ib.gray_req, ib.gray_addr, ib.lbp_valid, ib.lbp_addr, ib.lbp_data);
  always @(posedge clk) mon(2'd2, ic.gray_req, {8'd0, ic.gray_addr}, ic.lbp_valid,
                            {8'd0, ic.lbp_addr}, ic.lbp_data);

  task automatic clr(input logic [1:0] d);
    req_cnt[d] = 0; req_err[d] = 0; req_next[d] = 0;
    wr_cnt[d] = 0;  wr_err[d] = 0;  wr_last[d] = -1;
    for (int a = 0; a < NA; a++) begin
      lm[d][14'(a)] = 8'h00;
      wn[d][14'(a)] = 0;
    end
  endtask

  function automatic logic fin(input logic [1:0] d);
    case (d)
      2'd0:    return ia.finish;
      2'd1:    return ib.finish;
      default: return ic.finish;
    endcase
  endfunction

  task automatic wait_fin(input logic [1:0] d, input string tag, output int cyc);
    cyc = 0;
    while (fin(d) !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_finish"}, 32'(fin(d)), 32'd1);
  endtask

  task automatic wait_addr_a(input int target, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge clk);
      if (ia.gray_req === 1'b1 && int'(ia.gray_addr) == target) seen = 1'b1;
    end
  endtask

  // Reference LBP from the stored image; also the expected per-address write count.
  task automatic gold(input logic [1:0] d, input int lw, input int lh, input bit bw,
                      output int code_err, output int cnt_err);
    int w, h, c, g, want, wantn;
    int dx[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dy[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    w = 1 << lw;
    h = 1 << lh;
    code_err = 0;
    cnt_err  = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        bit inner;
        inner = (x > 0) && (x < w - 1) && (y > 0) && (y < h - 1);
        want  = 0;
        if (inner) begin
          c = int'(gm[d][14'(y * w + x)]);
          for (int k = 0; k < 8; k++) begin
            g = int'(gm[d][14'((y + dy[k]) * w + x + dx[k])]);
            if (g >= c) want = want | (1 << k);
          end
        end
        wantn = (inner || bw) ? 1 : 0;
        if (int'(lm[d][14'(y * w + x)]) != want) code_err++;
        if (wn[d][14'(y * w + x)] != wantn) cnt_err++;
      end
    end
  endtask

  initial begin
    int  lat, ce, we, bad, bad2;
    bit  seen;
    reset = 1'b1;
    ia.gray_ready = 1'b0;
    ib.gray_ready = 1'b0;
    ic.gray_ready = 1'b0;
    for (int d = 0; d < 3; d++) clr(2'(d));
    for (int a = 0; a < NA; a++) begin
      gm[0][14'(a)] = 10'h080;
      gm[1][14'(a)] = 10'(a % 128);
      gm[2][14'(a)] = (a < 64) ? 10'($urandom_range(0, 1023)) : 10'h000;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gray_req",  32'(ia.gray_req),  0);
    chk("rst_gray_addr", 32'(ia.gray_addr), 0);
    chk("rst_lbp_valid", 32'(ia.lbp_valid), 0);
    chk("rst_lbp_addr",  32'(ia.lbp_addr),  0);
    chk("rst_lbp_data",  32'(ia.lbp_data),  0);
    chk("rst_finish",    32'(ia.finish),    0);
    @(negedge clk);
    reset = 1'b0;

    // Flat 0x80 frame, no border writes, with a 5-cycle stall at address 300
    ia.gray_ready = 1'b1;
    wait_addr_a(300, seen);
    chk("reach_addr300", 32'(seen), 1);
    ia.gray_ready = 1'b0;
    bad  = 0;
    bad2 = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ia.gray_req !== 1'b0) bad++;
      if (ia.gray_addr !== 14'd300) bad2++;
      @(negedge clk);
    end
    chk("stall_req_low",   32'(bad),  0);
    chk("stall_addr_hold", 32'(bad2), 0);
    ia.gray_ready = 1'b1;
    wait_fin(2'd0, "flat", lat);
    chk("flat_req_cnt",   32'(req_cnt[0]), NA);
    chk("flat_req_seq",   32'(req_err[0]), 0);
    chk("flat_wr_cnt",    32'(wr_cnt[0]),  126 * 126);
    chk("flat_wr_order",  32'(wr_err[0]),  0);
    chk("flat_last_addr", 32'(wr_last[0]), 126 * 128 + 126);
    chk("flat_code_129",  32'(lm[0][14'd129]), 32'hFF);
    chk("flat_border_0_untouched", 32'(wn[0][14'd0]), 0);
    gold(2'd0, 7, 7, 1'b0, ce, we);
    chk("flat_gold_codes",  32'(ce), 0);
    chk("flat_gold_writes", 32'(we), 0);

    // Random frame aborted by reset at address 5000, then rerun from scratch
    ia.gray_ready = 1'b0;
    for (int a = 0; a < NA; a++) gm[0][14'(a)] = 10'($urandom_range(0, 255));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clr(2'd0);
    reset = 1'b0;
    ia.gray_ready = 1'b1;
    wait_addr_a(5000, seen);
    chk("reach_addr5000", 32'(seen), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_gray_req",  32'(ia.gray_req),  0);
    chk("midrst_gray_addr", 32'(ia.gray_addr), 0);
    chk("midrst_lbp_valid", 32'(ia.lbp_valid), 0);
    chk("midrst_lbp_addr",  32'(ia.lbp_addr),  0);
    chk("midrst_lbp_data",  32'(ia.lbp_data),  0);
    chk("midrst_finish",    32'(ia.finish),    0);
    @(negedge clk);
    clr(2'd0);
    reset = 1'b0;
    wait_fin(2'd0, "rerun", lat);
    chk("rerun_req_cnt",  32'(req_cnt[0]), NA);
    chk("rerun_req_seq",  32'(req_err[0]), 0);
    chk("rerun_wr_cnt",   32'(wr_cnt[0]),  126 * 126);
    chk("rerun_wr_order", 32'(wr_err[0]),  0);
    gold(2'd0, 7, 7, 1'b0, ce, we);
    chk("rerun_gold_codes",  32'(ce), 0);
    chk("rerun_gold_writes", 32'(we), 0);

    // Quiet and sticky after finish
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ia.finish !== 1'b1 || ia.gray_req !== 1'b0 || ia.lbp_valid !== 1'b0) bad++;
    end
    chk("post_finish_quiet", 32'(bad), 0);

    // Horizontal ramp with border writes
    ib.gray_ready = 1'b1;
    wait_fin(2'd1, "ramp", lat);
    chk("ramp_latency_ok",  32'((lat - 1) <= NA + 2 * 128 + 4), 1);
    chk("ramp_req_cnt",     32'(req_cnt[1]), NA);
    chk("ramp_req_seq",     32'(req_err[1]), 0);
    chk("ramp_wr_cnt",      32'(wr_cnt[1]),  NA);
    chk("ramp_wr_order",    32'(wr_err[1]),  0);
    chk("ramp_last_addr",   32'(wr_last[1]), NA - 1);
    chk("ramp_code_130",    32'(lm[1][14'd130]), 32'hD6);
    chk("ramp_code_1000",   32'(lm[1][14'd1000]), 32'hD6);
    chk("ramp_border_0_wr", 32'(wn[1][14'd0]), 1);
    chk("ramp_border_127",  32'(lm[1][14'd127]), 0);
    gold(2'd1, 7, 7, 1'b1, ce, we);
    chk("ramp_gold_codes",  32'(ce), 0);
    chk("ramp_gold_writes", 32'(we), 0);

    // 8x8, 10-bit random pixels
    ic.gray_ready = 1'b1;
    wait_fin(2'd2, "rand8", lat);
    chk("rand8_req_cnt",   32'(req_cnt[2]), 64);
    chk("rand8_req_seq",   32'(req_err[2]), 0);
    chk("rand8_wr_cnt",    32'(wr_cnt[2]),  36);
    chk("rand8_wr_order",  32'(wr_err[2]),  0);
    chk("rand8_last_addr", 32'(wr_last[2]), 6 * 8 + 6);
    gold(2'd2, 3, 3, 1'b0, ce, we);
    chk("rand8_gold_codes",  32'(ce), 0);
    chk("rand8_gold_writes", 32'(we), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
